// File: rtl/burst_addr_sequencer.sv
// Burst address sequencer: round-robin arbitration of burst requests and
// control of one shared external address counter to emit per-beat addresses
// on a valid/ready beat stream.
//
// Beat interface handshake: a beat transfers on any rising edge where
// o_beat_valid && i_beat_ready. Once o_beat_valid is high, valid, addr, last
// and id stay stable until that transfer occurs. Request side: o_req_ready is
// one-hot and combinational, and the request is taken on the edge where
// i_req_valid[k] && o_req_ready[k].
module burst_addr_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_BYTES = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int NUM_REQ    = 2,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    i_req_len,
  output logic                            o_cnt_load,
  output logic                            o_cnt_en,
  output logic [ADDR_WIDTH-1:0]           o_cnt_addr,
  input  logic [ADDR_WIDTH-1:0]           i_cnt_addr,
  output logic                            o_beat_valid,
  input  logic                            i_beat_ready,
  output logic [ADDR_WIDTH-1:0]           o_beat_addr,
  output logic                            o_beat_last,
  output logic [ID_W-1:0]                 o_beat_id,
  output logic                            o_busy,
  output logic                            o_done
);

  // Clearing the low log2(BEAT_BYTES) bits truncates misaligned starts.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BEAT_BYTES - 1));

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        last_grant_q;
  logic                   done_q;

  logic                   any_valid;
  logic                   hi_found;
  logic [ID_W-1:0]        hi_idx;
  logic [ID_W-1:0]        lo_idx;
  logic [ID_W-1:0]        win;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [LEN_WIDTH-1:0]   win_len;
  logic                   beat_last;

  // Round-robin pick: lowest valid index above last_grant, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        lo_idx = ID_W'(k);
        if (k > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(k);
        end
      end
    end
    win       = hi_found ? hi_idx : lo_idx;
    any_valid = |i_req_valid;
    win_addr  = i_req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] & ALIGN_MASK;
    win_len   = i_req_len[int'(win)*LEN_WIDTH +: LEN_WIDTH];
    beat_last = (remaining_q == '0);
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    o_req_ready  = '0;
    o_cnt_load   = 1'b0;
    o_cnt_en     = 1'b0;
    o_cnt_addr   = '0;
    o_beat_valid = 1'b0;
    o_beat_addr  = '0;
    o_beat_last  = 1'b0;
    o_beat_id    = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    if (!i_rst) begin
      o_done = done_q;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            o_req_ready[win] = 1'b1;
            o_cnt_load       = 1'b1;
            o_cnt_en         = 1'b1;
            o_cnt_addr       = win_addr;
          end
        end
        BURST: begin
          o_busy       = 1'b1;
          o_beat_valid = 1'b1;
          o_beat_addr  = i_cnt_addr;
          o_beat_last  = beat_last;
          o_beat_id    = id_q;
          // Step the counter only on a non-final beat transfer.
          o_cnt_en     = i_beat_ready && !beat_last;
        end
        default: ;
      endcase
    end
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            remaining_q  <= win_len;
            id_q         <= win;
            last_grant_q <= win;
            state_q      <= BURST;
          end
        end
        BURST: begin
          if (i_beat_ready) begin
            if (beat_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_addr_sequencer.sv
// Testbench for burst_addr_sequencer: directed scenarios plus a randomized
// run checked against a beat-list reference model with an expected queue.
module tb_burst_addr_sequencer;

  localparam int AW = 32;
  localparam int BB = 4;
  localparam int LW = 4;
  localparam int NR = 2;
  localparam int IDW = 1;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst = 1'b1;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR-1:0]     o_req_ready;
  logic [NR*AW-1:0]  i_req_addr = '0;
  logic [NR*LW-1:0]  i_req_len = '0;
  logic              o_cnt_load;
  logic              o_cnt_en;
  logic [AW-1:0]     o_cnt_addr;
  logic [AW-1:0]     cnt_m = '0;
  logic              o_beat_valid;
  logic              i_beat_ready = 1'b0;
  logic [AW-1:0]     o_beat_addr;
  logic              o_beat_last;
  logic [IDW-1:0]    o_beat_id;
  logic              o_busy;
  logic              o_done;

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard entries: {id, last, addr}
  logic [33:0] exp_q[$];

  burst_addr_sequencer #(.ADDR_WIDTH(AW), .BEAT_BYTES(BB), .LEN_WIDTH(LW), .NUM_REQ(NR)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .o_cnt_load(o_cnt_load), .o_cnt_en(o_cnt_en), .o_cnt_addr(o_cnt_addr),
    .i_cnt_addr(cnt_m),
    .o_beat_valid(o_beat_valid), .i_beat_ready(i_beat_ready),
    .o_beat_addr(o_beat_addr), .o_beat_last(o_beat_last), .o_beat_id(o_beat_id),
    .o_busy(o_busy), .o_done(o_done)
  );

  // External address counter behaving to the load/enable contract.
  always @(posedge clk) begin
    if (o_cnt_en) cnt_m <= o_cnt_load ? o_cnt_addr : cnt_m + AW'(BB);
  end

  // Driver tasks
  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
    i_req_addr[k*AW +: AW] = a;
    i_req_len[k*LW +: LW]  = l;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_rst = 1'b1; i_req_valid = '0; i_beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  function automatic logic [34:0] beat_obs();
    return {o_beat_valid, o_beat_id, o_beat_last, o_beat_addr};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    i_rst = 1'b1; i_req_valid = 2'b11; i_beat_ready = 1'b1;
    set_req(0, 32'h100, 4'd0); set_req(1, 32'h200, 4'd0);
    #1;
    n_checks++;
    if ({o_req_ready, o_cnt_en, o_cnt_load, o_beat_valid, o_busy, o_done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {o_req_ready, o_cnt_en, o_cnt_load, o_beat_valid, o_busy, o_done});
    end
    @(negedge clk); i_rst = 1'b0; #1;
    n_checks++;
    if ({o_req_ready, o_busy} !== 3'b010) begin
      n_fail++; $display("FAIL reset_first_tie: got %b want 010", {o_req_ready, o_busy});
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b01; set_req(0, 32'hDEEF0000, 4'd3); i_beat_ready = 1'b1; #1;
    n_checks++;
    if ({o_req_ready, o_cnt_load, o_cnt_en, o_cnt_addr, o_beat_valid} !== {2'b01, 1'b1, 1'b1, 32'hDEEF0000, 1'b0}) begin
      n_fail++; $display("FAIL single_accept: ready=%b load=%b en=%b addr=%h want 01 1 1 deef0000", o_req_ready, o_cnt_load, o_cnt_en, o_cnt_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_req_valid = '0; #1;
      n_checks++;
      if (beat_obs() !== {1'b1, 1'b0, (i == 3), 32'hDEEF0000 + AW'(4*i)}) begin
        n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, beat_obs(), {1'b1, 1'b0, (i == 3), 32'hDEEF0000 + AW'(4*i)});
      end
      n_checks++;
      if (o_cnt_en !== (i != 3)) begin
        n_fail++; $display("FAIL single_cnt_en%0d: got %b want %b", i, o_cnt_en, (i != 3));
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_done, o_beat_valid, o_busy} !== 3'b100) begin
      n_fail++; $display("FAIL single_done: got %b want 100", {o_done, o_beat_valid, o_busy});
    end
    @(negedge clk); #1;
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_pulse: got %b want 0", o_done);
    end
  endtask

  task automatic test_backpressure();
    int rdy[7] = '{1, 0, 0, 0, 1, 1, 1};
    int off[7] = '{0, 4, 4, 4, 4, 8, 12};
    int hs = 0;
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b01; set_req(0, 32'hDEEF0000, 4'd3); i_beat_ready = 1'b1; #1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); i_req_valid = '0; i_beat_ready = rdy[c][0]; #1;
      n_checks++;
      if (beat_obs() !== {1'b1, 1'b0, (off[c] == 12), 32'hDEEF0000 + AW'(off[c])}) begin
        n_fail++; $display("FAIL bp_beat_c%0d: got %h want %h", c, beat_obs(), {1'b1, 1'b0, (off[c] == 12), 32'hDEEF0000 + AW'(off[c])});
      end
      n_checks++;
      if (o_cnt_en !== (rdy[c] == 1 && off[c] != 12)) begin
        n_fail++; $display("FAIL bp_cnt_en_c%0d: got %b want %b", c, o_cnt_en, (rdy[c] == 1 && off[c] != 12));
      end
      if (o_beat_valid && i_beat_ready) hs++;
    end
    @(negedge clk); #1;
    n_checks++;
    if ({hs == 4, o_done, o_beat_valid} !== 3'b110) begin
      n_fail++; $display("FAIL bp_count: beats=%0d done=%b valid=%b want 4 1 0", hs, o_done, o_beat_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] base;
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b11; i_beat_ready = 1'b1;
    set_req(0, 32'h1000, 4'd1); set_req(1, 32'h2000, 4'd1);
    for (int b = 0; b < 4; b++) begin
      base = (b % 2 == 1) ? 32'h2000 : 32'h1000;
      if (b != 0) @(negedge clk);
      #1;
      n_checks++;
      if ({o_req_ready, o_cnt_addr, o_busy, o_done} !== {((b % 2 == 1) ? 2'b10 : 2'b01), base, 1'b0, (b != 0)}) begin
        n_fail++; $display("FAIL rr_grant%0d: ready=%b addr=%h busy=%b done=%b", b, o_req_ready, o_cnt_addr, o_busy, o_done);
      end
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); #1;
        n_checks++;
        if (beat_obs() !== {1'b1, (b % 2 == 1), (i == 1), base + AW'(4*i)}) begin
          n_fail++; $display("FAIL rr_beat%0d_%0d: got %h want %h", b, i, beat_obs(), {1'b1, (b % 2 == 1), (i == 1), base + AW'(4*i)});
        end
      end
    end
    @(negedge clk); i_req_valid = '0;
  endtask

  task automatic test_wrap_misaligned();
    logic [AW-1:0] ea[4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b10; set_req(1, 32'hFFFFFFFB, 4'd3); i_beat_ready = 1'b1; #1;
    n_checks++;
    if ({o_req_ready, o_cnt_addr} !== {2'b10, 32'hFFFFFFF8}) begin
      n_fail++; $display("FAIL wrap_accept: ready=%b addr=%h want 10 fffffff8", o_req_ready, o_cnt_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_req_valid = '0; #1;
      n_checks++;
      if (beat_obs() !== {1'b1, 1'b1, (i == 3), ea[i]}) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %h want %h", i, beat_obs(), {1'b1, 1'b1, (i == 3), ea[i]});
      end
    end
  endtask

  task automatic test_single_beat();
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b01; set_req(0, 32'h40, 4'd0); i_beat_ready = 1'b1; #1;
    n_checks++;
    if ({o_cnt_en, o_cnt_load, o_cnt_addr} !== {1'b1, 1'b1, 32'h40}) begin
      n_fail++; $display("FAIL sb_load: en=%b load=%b addr=%h want 1 1 40", o_cnt_en, o_cnt_load, o_cnt_addr);
    end
    @(negedge clk); i_req_valid = '0; #1;
    n_checks++;
    if ({beat_obs(), o_cnt_en} !== {1'b1, 1'b0, 1'b1, 32'h40, 1'b0}) begin
      n_fail++; $display("FAIL sb_beat: got %h want %h", {beat_obs(), o_cnt_en}, {1'b1, 1'b0, 1'b1, 32'h40, 1'b0});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({o_done, o_cnt_en, o_beat_valid, cnt_m} !== {1'b1, 1'b0, 1'b0, 32'h40}) begin
      n_fail++; $display("FAIL sb_done: done=%b en=%b valid=%b cnt=%h want 1 0 0 40", o_done, o_cnt_en, o_beat_valid, cnt_m);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    @(negedge clk);
    i_req_valid = 2'b01; set_req(0, 32'h300, 4'd7); i_beat_ready = 1'b1;
    @(negedge clk); i_req_valid = '0;
    @(negedge clk); i_rst = 1'b1; #1;
    n_checks++;
    if ({o_beat_valid, o_busy, o_done, o_cnt_en} !== 4'b0) begin
      n_fail++; $display("FAIL rmb_in_reset: got %b want 0000", {o_beat_valid, o_busy, o_done, o_cnt_en});
    end
    @(negedge clk); i_rst = 1'b0; #1;
    n_checks++;
    if ({o_beat_valid, o_busy, o_done, cnt_m} !== {3'b000, 32'h304}) begin
      n_fail++; $display("FAIL rmb_after: v/b/d=%b cnt=%h want 000 304", {o_beat_valid, o_busy, o_done}, cnt_m);
    end
    @(negedge clk);
    i_req_valid = 2'b01; set_req(0, 32'h80, 4'd0); #1;
    n_checks++;
    if ({o_req_ready, o_cnt_addr} !== {2'b01, 32'h80}) begin
      n_fail++; $display("FAIL rmb_regrant: ready=%b addr=%h want 01 80", o_req_ready, o_cnt_addr);
    end
    @(negedge clk); i_req_valid = '0; #1;
    n_checks++;
    if (beat_obs() !== {1'b1, 1'b0, 1'b1, 32'h80}) begin
      n_fail++; $display("FAIL rmb_beat: got %h want %h", beat_obs(), {1'b1, 1'b0, 1'b1, 32'h80});
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] pend = '0;
    logic [NR-1:0] exp_rdy;
    logic [AW-1:0] ra[NR];
    logic [LW-1:0] rl[NR];
    logic [AW-1:0] base;
    logic [33:0]   e;
    int lg = NR - 1;
    int w;
    bit busy_m = 0;
    bit done_m = 0;
    bit drain;
    apply_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 700; cyc++) begin
      drain = (cyc >= 600);
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && !drain && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          ra[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | AW'($urandom_range(0, 15))) : AW'($urandom);
          rl[k] = LW'($urandom_range(0, 15));
          set_req(k, ra[k], rl[k]);
        end
      end
      i_req_valid  = pend;
      i_beat_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if ({o_done, o_busy} !== {done_m, busy_m}) begin
        n_fail++; $display("FAIL rnd_state c%0d: done/busy=%b want %b", cyc, {o_done, o_busy}, {done_m, busy_m});
      end
      done_m = 0;
      if (!busy_m) begin
        exp_rdy = '0;
        w = -1;
        for (int j = 1; j <= NR; j++) begin
          if (w < 0 && pend[(lg + j) % NR]) w = (lg + j) % NR;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        n_checks++;
        if ({o_req_ready, o_beat_valid} !== {exp_rdy, 1'b0}) begin
          n_fail++; $display("FAIL rnd_grant c%0d: ready=%b valid=%b want %b 0", cyc, o_req_ready, o_beat_valid, exp_rdy);
        end
        if (w >= 0) begin
          base = ra[w] & ~AW'(BB - 1);
          n_checks++;
          if ({o_cnt_load, o_cnt_en, o_cnt_addr} !== {2'b11, base}) begin
            n_fail++; $display("FAIL rnd_load c%0d: got %h want %h", cyc, {o_cnt_load, o_cnt_en, o_cnt_addr}, {2'b11, base});
          end
          for (int i = 0; i <= int'(rl[w]); i++) exp_q.push_back({w[0], (i == int'(rl[w])), base + AW'(BB*i)});
          pend[w] = 1'b0;
          lg = w;
          busy_m = 1;
        end
      end else if (exp_q.size() > 0) begin
        n_checks++;
        if ({o_req_ready, beat_obs()} !== {2'b00, 1'b1, exp_q[0]}) begin
          n_fail++; $display("FAIL rnd_beat c%0d: got %h want %h", cyc, {o_req_ready, beat_obs()}, {2'b00, 1'b1, exp_q[0]});
        end
        n_checks++;
        if ({o_cnt_en, o_cnt_load} !== {(i_beat_ready && !exp_q[0][32]), 1'b0}) begin
          n_fail++; $display("FAIL rnd_cnt c%0d: en/load=%b want %b", cyc, {o_cnt_en, o_cnt_load}, {(i_beat_ready && !exp_q[0][32]), 1'b0});
        end
        if (i_beat_ready) begin
          e = exp_q.pop_front();
          if (e[32]) begin
            busy_m = 0;
            done_m = 1;
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || pend != '0) begin
      n_fail++; $display("FAIL rnd_drain: %0d beats outstanding, pending=%b want 0 0", exp_q.size(), pend);
    end
    @(negedge clk); i_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_round_robin();
    test_wrap_misaligned();
    test_single_beat();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_addr_sequencer.md
Name: burst_addr_sequencer

Overview:
- Arbitrates burst requests from NUM_REQ requesters, such as instruction fetch and data refill, and sequences one shared address counter (WIDTH=ADDR_WIDTH, STEP=BEAT_BYTES) to generate per-beat physical addresses.
- Drives the counter's load/enable/load-value pins and reads its current output.
- Presents beats downstream on a valid/ready interface with a last flag and a requester ID.
- Sits between the cache/fetch front ends and the memory bus adapter.

Parameters:
- ADDR_WIDTH, 32 (PADDR_WIDTH): address width.
- BEAT_BYTES, 4: bytes per beat and counter STEP; must be a power of 2.
- LEN_WIDTH, 4: width of the burst length field, encoded as beats-1 (max 16 beats).
- NUM_REQ, 2: number of requesters; must be >= 1. ID_W = max(1, $clog2(NUM_REQ)).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  one-hot accept
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_len  in  NUM_REQ*LEN_WIDTH  packed beats-1
- o_cnt_load  out  1  counter load select
- o_cnt_en  out  1  counter enable
- o_cnt_addr  out  ADDR_WIDTH  counter load value
- i_cnt_addr  in  ADDR_WIDTH  counter current output
- o_beat_valid  out  1  beat valid
- i_beat_ready  in  1  downstream accepts beat
- o_beat_addr  out  ADDR_WIDTH  beat address
- o_beat_last  out  1  final beat of burst
- o_beat_id  out  ID_W  granted requester index
- o_busy  out  1  high when not IDLE
- o_done  out  1  one-cycle pulse the cycle after the last-beat handshake

Behaviour:
- Counter contract:
  - en&&load loads o_cnt_addr at the next edge.
  - en&&!load adds BEAT_BYTES at the next edge, wrapping modulo 2^ADDR_WIDTH.
  - !en holds the value.
  - This block never asserts o_cnt_load without o_cnt_en.
- FSM states: IDLE, BURST. Reset state is IDLE.
- IDLE, no request: all outputs 0.
- IDLE, any i_req_valid set:
  - Round-robin winner w is the first valid index after last_grant, wrapping.
  - o_req_ready[w]=1 combinationally; the request is accepted that cycle.
  - o_cnt_load=o_cnt_en=1.
  - o_cnt_addr = i_req_addr[w] with the low log2(BEAT_BYTES) bits forced to 0 (misaligned starts are truncated).
  - Registers: remaining <= i_req_len[w], id <= w, last_grant <= w.
  - Next state: BURST.
- BURST:
  - o_beat_valid=1, o_beat_addr=i_cnt_addr, o_beat_id=id, o_beat_last=(remaining==0).
  - o_req_ready=0 for all requesters; no preemption.
- Beat handshake (o_beat_valid && i_beat_ready), not last: o_cnt_en=1 (load=0) and remaining decrements. The next address appears the following cycle.
- Last-beat handshake: go to IDLE; o_done=1 on the next cycle, which is an IDLE cycle.
- Backpressure: while i_beat_ready=0, valid, addr, last and id hold stable and o_cnt_en=0.
- Latency:
  - Accept at cycle N gives first beat valid at N+1.
  - With ready held high, an L-beat burst occupies N+1..N+L.
  - The next accept can occur at N+L+1; the minimum inter-burst gap is 1 cycle.
- Single-beat burst (len 0): the first beat has last=1 and the counter is not stepped.
- Wrap-around: addresses wrap modulo 2^ADDR_WIDTH with no error.
- Requester protocol: valid should hold until ready. If valid drops before grant, the arbiter simply re-evaluates each IDLE cycle. Non-winning requesters see ready=0.
- Reset:
  - Reset value of last_grant is NUM_REQ-1, so requester 0 wins the first tie.
  - Reset mid-burst: state to IDLE next cycle; all outputs 0 including o_done; the burst is dropped and the counter is not touched (en=0) during reset.
- o_busy = (state==BURST).

Test Plan:
- Single burst: req0 addr 0xDEEF0000, len 3, ready high.
  - Ready0 at N.
  - Beats 0xDEEF0000, 0xDEEF0004, 0xDEEF0008, 0xDEEF000C at N+1..N+4, id 0, last only on 0xDEEF000C.
  - o_done at N+5.
- Backpressure: same burst, i_beat_ready low for 3 cycles on beat 2.
  - 0xDEEF0004 held valid and stable for 4 cycles; o_cnt_en=0 while stalled.
  - 4 beats total; no duplicates.
- Round-robin: req0 and req1 held valid continuously, each len 1 (addrs 0x1000, 0x2000).
  - Grants alternate 0,1,0,1.
  - Beats 0x1000, 0x1004 (id 0), then 0x2000, 0x2004 (id 1).
  - One idle cycle between bursts.
- Wrap and misaligned: req1 addr 0xFFFFFFFB, len 3.
  - Beats 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004, id 1.
- Single beat: req0 addr 0x40, len 0.
  - One beat 0x40 with last=1; counter en asserted only in the load cycle.
- Reset mid-burst: assert i_rst during beat 2 of a len-7 burst.
  - Next cycle valid/busy/done=0.
  - After release, new req0 addr 0x80, len 0 → beat 0x80, id 0.
